charge_meter: RTL and testbench
===============================

# charge_meter

Parametrised throw-strength meter for the game overlay stage of the VGA pipeline. While the charge button is held, a horizontal bar fills at a fixed rate. On release, the bar value is latched as the throw force and a one-cycle valid pulse is issued. The block overlays the bar, including its empty track, on the passing VGA stream with one registered pipeline stage, and keeps the captured bar visible for a configurable hold time.

## Interface
Parameters:
- X_START, 876: left pixel column of the bar.
- Y_START, 400: top pixel row of the bar.
- HEIGHT, 21: bar height in rows.
- MAX_WIDTH, 128: full-scale level, in pixels. Legal range 1–1023.
- STEP_INTERVAL, 1_234_177: clk cycles per one-pixel level step. Must be at least 1.
- HOLD_CYCLES, 65_000_000: cycles the latched bar remains displayed after release. A value of 0 means no hold.
- FILL_COLOR, 12'hF00: RGB of the filled part of the bar.
- TRACK_COLOR, 12'h444: RGB of the unfilled part of the bar.

Ports:
- clk, input, 1: pixel clock.
- rst, input, 1: asynchronous, active-high reset.
- charge_btn, input, 1: charge request. Already synchronous to clk; high means held.
- throw_force, output, 10: last captured level, zero-extended.
- force_valid, output, 1: one-cycle pulse when throw_force updates.
- busy, output, 1: high in CHARGE or HOLD.
- vga_in, vga_if input modport: upstream timing and rgb.
- vga_out, vga_if output modport: downstream timing and rgb.

## Operation
- **State machine.** The states are IDLE, CHARGE and HOLD.
  - IDLE → CHARGE on a rising edge of charge_btn. Entering CHARGE clears the level and the prescaler.
  - CHARGE → HOLD on a falling edge of charge_btn. In the same transition, the current level is latched into throw_force and force_valid is pulsed. The hold counter is cleared.
  - HOLD → IDLE when the hold counter reaches HOLD_CYCLES−1. If HOLD_CYCLES=0, CHARGE goes directly to IDLE.
  - HOLD → CHARGE on a rising edge of charge_btn. The level restarts from 0. throw_force keeps its old value until the next release.
- **Edge detection.** Edges are found against a registered copy of charge_btn. That copy resets to 0, so a button already held when reset is released produces a rising edge on the first active cycle.
- **Prescaler.** The prescaler is 32 bits wide. In CHARGE it counts 0 to STEP_INTERVAL−1. On reaching the terminal count it wraps to 0 and steps the level, so each step takes exactly STEP_INTERVAL cycles.
- **Level.** The level is $clog2(MAX_WIDTH+1) bits wide. It saturates at MAX_WIDTH; once saturated, the prescaler stops counting. Step behaviour at the top depends on the macro in the Configuration section.
- **Release coinciding with a step.** The captured value is the pre-step level, and that step is discarded.
- **Pixel test.** The pixel test uses vga_in.hcount and vga_in.vcount.
  - Bar region: X_START ≤ hcount < X_START+MAX_WIDTH and Y_START ≤ vcount < Y_START+HEIGHT.
  - Inside the region, when busy: pixels with hcount < X_START+level get FILL_COLOR; the rest get TRACK_COLOR.
  - Otherwise vga_in.rgb passes through.
  - In HOLD, the level shown is the captured level.
- **Reset.** Reset has immediate effect, including mid-charge. It forces IDLE and clears level, prescaler and hold counter. throw_force resets to 0 and force_valid to 0. Every vga_out field resets to 0.

## Timing
- vga_out is registered: all six timing fields and rgb have exactly 1 cycle of latency relative to vga_in. The overlay decision is aligned with the delayed timing.
- throw_force and force_valid are registered. They update on the cycle after the first clk edge that samples charge_btn=0 in CHARGE.
- busy reflects the registered state, with no combinational path from charge_btn.
- A charge of N full steps held for exactly N·STEP_INTERVAL cycles in CHARGE yields throw_force=N, provided N ≤ MAX_WIDTH.

## Configuration
- CHARGE_METER_PINGPONG_EN
  - When defined, the level reverses direction on reaching MAX_WIDTH and counts down to 0, then up again, for as long as the button is held.
  - The direction flag is cleared on entry to CHARGE and on reset.
  - When undefined, the level saturates at MAX_WIDTH and no direction logic is generated.

## Structure
- Shared package vga_pkg holds:
  - the meter_state_t enum for IDLE, CHARGE and HOLD;
  - the default colour constants used for FILL_COLOR and TRACK_COLOR;
  - the screen-dimension constants used to range-check X_START and Y_START.
- One sub-module, step_timer, provides the parametrised prescaler. Its signals are enable, clear and a terminal-count pulse out. It is instantiated twice: once for level steps and once for the hold timer.

## Test plan
Bench parameters: STEP_INTERVAL=4, MAX_WIDTH=8, HOLD_CYCLES=10.
- **Basic charge.** Hold charge_btn for 12 CHARGE cycles, then release → throw_force=3, force_valid high for exactly 1 cycle, state HOLD for 10 cycles, then IDLE.
- **Saturation (macro undefined).** Hold for 100 cycles → level stops at 8; release gives throw_force=8.
- **Ping-pong (macro defined).** Hold for 40 cycles → level rises 0→8, then falls back to 6; release gives throw_force=6.
- **Reset mid-charge.** Assert rst at level 5 → busy=0, throw_force=0 and vga_out.rgb=0 immediately. After reset is released with the button low, no force_valid pulse occurs.
- **Overlay.** With level=3 in HOLD, a vga_in scan of row Y_START:
  - columns X_START..X_START+2 output 12'hF00;
  - columns X_START+3..X_START+7 output 12'h444;
  - column X_START+8 passes vga_in.rgb;
  - all outputs appear 1 cycle after the corresponding input.
- **Re-press in HOLD.** Press again during HOLD → state CHARGE with level 0, and throw_force keeps its previous value until the next release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA overlay definitions: timing/colour widths, screen limits,
// default bar colours and the charge meter state encoding.
package vga_pkg;

    localparam int COORD_W  = 11;
    localparam int RGB_W    = 12;
    localparam int H_ACTIVE = 1024;
    localparam int V_ACTIVE = 768;

    localparam logic [RGB_W-1:0] DEFAULT_FILL_COLOR  = 12'hF00;
    localparam logic [RGB_W-1:0] DEFAULT_TRACK_COLOR = 12'h444;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHARGE = 2'd1,
        ST_HOLD   = 2'd2
    } meter_state_t;

endpackage

// File: rtl/vga_if.sv
// VGA stream bundle: six timing fields plus rgb. master drives, slave observes.
interface vga_if;
    import vga_pkg::*;

    logic [COORD_W-1:0] hcount;
    logic [COORD_W-1:0] vcount;
    logic               hsync;
    logic               vsync;
    logic               hblank;
    logic               vblank;
    logic [RGB_W-1:0]   rgb;

    modport master (output hcount, vcount, hsync, vsync, hblank, vblank, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblank, vblank, rgb);

endinterface

// File: rtl/step_timer.sv
// Free-running prescaler: counts 0..COUNT-1 while enabled and pulses tc
// on the terminal count, wrapping to 0 on the same edge.
module step_timer #(
    parameter int unsigned COUNT = 1,
    parameter int          WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(COUNT - 1);

    logic [WIDTH-1:0] cnt;

    assign tc = enable && (cnt == LAST);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/charge_meter.sv
// Throw-strength meter with VGA bar overlay (one registered pixel stage).
// Define CHARGE_METER_PINGPONG_EN to make the level bounce between 0 and MAX_WIDTH.
module charge_meter
    import vga_pkg::*;
#(
    parameter int               X_START       = 876,
    parameter int               Y_START       = 400,
    parameter int               HEIGHT        = 21,
    parameter int               MAX_WIDTH     = 128,
    parameter int unsigned      STEP_INTERVAL = 1_234_177,
    parameter int unsigned      HOLD_CYCLES   = 65_000_000,
    parameter logic [RGB_W-1:0] FILL_COLOR    = DEFAULT_FILL_COLOR,
    parameter logic [RGB_W-1:0] TRACK_COLOR   = DEFAULT_TRACK_COLOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        charge_btn,
    output logic [9:0]  throw_force,
    output logic        force_valid,
    output logic        busy,
    vga_if.slave        vga_in,
    vga_if.master       vga_out
);

    localparam int                 LW        = $clog2(MAX_WIDTH + 1);
    localparam logic [LW-1:0]      LEVEL_MAX = LW'(MAX_WIDTH);
    localparam logic [COORD_W-1:0] X_LO      = COORD_W'(X_START);
    localparam logic [COORD_W-1:0] X_HI      = COORD_W'(X_START + MAX_WIDTH);
    localparam logic [COORD_W-1:0] Y_LO      = COORD_W'(Y_START);
    localparam logic [COORD_W-1:0] Y_HI      = COORD_W'(Y_START + HEIGHT);
    // A bar that would not fit on screen is never drawn.
    localparam bit BAR_ON_SCREEN = (X_START >= 0) && (X_START + MAX_WIDTH <= H_ACTIVE) &&
                                   (Y_START >= 0) && (Y_START + HEIGHT <= V_ACTIVE);
    localparam int unsigned HOLD_TIMER_COUNT = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;

    meter_state_t       state, next_state;
    logic               btn_q, rise, fall;
    logic               enter_charge, capture;
    logic               pre_en, step_tc, hold_tc;
    logic [LW-1:0]      level, shown_level;
    logic               in_bar;
    logic [COORD_W-1:0] fill_edge;
    logic [RGB_W-1:0]   pix_rgb;

    assign rise = charge_btn && !btn_q;
    assign fall = !charge_btn && btn_q;
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            btn_q <= 1'b0;
        end else begin
            state <= next_state;
            btn_q <= charge_btn;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state   = state;
        enter_charge = 1'b0;
        capture      = 1'b0;
        unique case (state)
            ST_IDLE: if (rise) begin
                next_state   = ST_CHARGE;
                enter_charge = 1'b1;
            end
            ST_CHARGE: if (fall) begin
                capture    = 1'b1;
                next_state = (HOLD_CYCLES == 0) ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: if (rise) begin
                next_state   = ST_CHARGE;
                enter_charge = 1'b1;
            end else if (hold_tc) begin
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    step_timer #(.COUNT(STEP_INTERVAL), .WIDTH(32)) u_step_timer (
        .clk(clk), .rst(rst), .enable(pre_en), .clear(enter_charge), .tc(step_tc)
    );

    step_timer #(.COUNT(HOLD_TIMER_COUNT), .WIDTH(32)) u_hold_timer (
        .clk(clk), .rst(rst), .enable(state == ST_HOLD), .clear(state != ST_HOLD), .tc(hold_tc)
    );

    // A step landing on the release edge is dropped; the pre-step level is captured.
`ifdef CHARGE_METER_PINGPONG_EN
    logic dir_down;

    assign pre_en = (state == ST_CHARGE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level    <= '0;
            dir_down <= 1'b0;
        end else if (enter_charge) begin
            level    <= '0;
            dir_down <= 1'b0;
        end else if (step_tc && !fall) begin
            if (dir_down) begin
                level <= level - 1'b1;
                if (level == LW'(1)) dir_down <= 1'b0;
            end else begin
                level <= level + 1'b1;
                if (level == LEVEL_MAX - 1'b1) dir_down <= 1'b1;
            end
        end
    end
`else
    assign pre_en = (state == ST_CHARGE) && (level != LEVEL_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else if (enter_charge) begin
            level <= '0;
        end else if (step_tc && !fall) begin
            level <= level + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            throw_force <= '0;
            force_valid <= 1'b0;
        end else begin
            force_valid <= capture;
            if (capture) throw_force <= 10'(level);
        end
    end

    always_comb begin
        shown_level = (state == ST_HOLD) ? throw_force[LW-1:0] : level;
        in_bar      = BAR_ON_SCREEN &&
                      (vga_in.hcount >= X_LO) && (vga_in.hcount < X_HI) &&
                      (vga_in.vcount >= Y_LO) && (vga_in.vcount < Y_HI);
        fill_edge   = X_LO + COORD_W'(shown_level);
        pix_rgb     = vga_in.rgb;
        if (busy && in_bar) begin
            pix_rgb = (vga_in.hcount < fill_edge) ? FILL_COLOR : TRACK_COLOR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblank <= 1'b0;
            vga_out.vblank <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.hcount <= vga_in.hcount;
            vga_out.vcount <= vga_in.vcount;
            vga_out.hsync  <= vga_in.hsync;
            vga_out.vsync  <= vga_in.vsync;
            vga_out.hblank <= vga_in.hblank;
            vga_out.vblank <= vga_in.vblank;
            vga_out.rgb    <= pix_rgb;
        end
    end

endmodule

// File: tb/tb_charge_meter.sv
// Directed bench for charge_meter (STEP_INTERVAL=4, MAX_WIDTH=8, HOLD_CYCLES=10);
// expectations follow CHARGE_METER_PINGPONG_EN when it is defined.
module tb_charge_meter;
    import vga_pkg::*;

    localparam int X0 = 876;
    localparam int Y0 = 400;

`ifdef CHARGE_METER_PINGPONG_EN
    localparam int EXP_HOLD100 = 7;
    localparam int EXP_HOLD40  = 6;
`else
    localparam int EXP_HOLD100 = 8;
    localparam int EXP_HOLD40  = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       charge_btn;
    logic [9:0] throw_force;
    logic       force_valid;
    logic       busy;

    vga_if vin ();
    vga_if vout ();

    charge_meter #(
        .STEP_INTERVAL(4),
        .MAX_WIDTH(8),
        .HOLD_CYCLES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .charge_btn(charge_btn),
        .throw_force(throw_force),
        .force_valid(force_valid),
        .busy(busy),
        .vga_in(vin),
        .vga_out(vout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int fv_count = 0;
    int fv_base;

    always @(posedge clk) if (force_valid === 1'b1) fv_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Rising edge, n held cycles in CHARGE, then the release edge.
    task automatic press_and_hold(input int n);
        charge_btn = 1'b1;
        tick(1);
        tick(n);
        charge_btn = 1'b0;
        tick(1);
    endtask

    task automatic set_pixel(input int col, input int row, input logic [11:0] color);
        vin.hcount = COORD_W'(col);
        vin.vcount = COORD_W'(row);
        vin.rgb    = color;
    endtask

    logic [11:0] exp_rgb;
    logic [11:0] pix;
    logic [10:0] prev_h;

    initial begin
        rst        = 1'b1;
        charge_btn = 1'b0;
        vin.hsync  = 1'b1;
        vin.vsync  = 1'b0;
        vin.hblank = 1'b0;
        vin.vblank = 1'b1;
        set_pixel(0, 0, 12'hABC);
        tick(2);

        check("reset_busy", busy, 0);
        check("reset_force", throw_force, 0);
        check("reset_valid", force_valid, 0);
        check("reset_rgb", vout.rgb, 0);
        check("reset_hsync", vout.hsync, 0);
        check("reset_vblank", vout.vblank, 0);

        rst = 1'b0;
        tick(2);
        check("pass_rgb", vout.rgb, 12'hABC);
        check("pass_hsync", vout.hsync, 1);
        check("pass_vblank", vout.vblank, 1);

        // Basic charge: 12 cycles -> 3, then 10 cycles of HOLD.
        fv_base = fv_count;
        press_and_hold(12);
        check("basic_valid", force_valid, 1);
        check("basic_force", throw_force, 3);
        check("basic_busy_hold", busy, 1);
        tick(1);
        check("basic_valid_drop", force_valid, 0);
        tick(8);
        check("basic_hold_end_busy", busy, 1);
        tick(1);
        check("basic_idle", busy, 0);
        check("basic_pulse_count", fv_count - fv_base, 1);

        press_and_hold(100);
        check("hold100_force", throw_force, EXP_HOLD100);
        tick(12);
        check("hold100_idle", busy, 0);

        press_and_hold(40);
        check("hold40_force", throw_force, EXP_HOLD40);
        tick(12);

        // Overlay scan of row Y0 in HOLD with captured level 3.
        press_and_hold(12);
        check("ovl_force", throw_force, 3);
        for (int k = 0; k <= 8; k++) begin
            prev_h = vout.hcount;
            pix    = 12'h0A0 + 12'(k);
            set_pixel(X0 + k, Y0, pix);
            #1;
            check("ovl_latency", vout.hcount, prev_h);
            tick(1);
            if (k < 3)      exp_rgb = 12'hF00;
            else if (k < 8) exp_rgb = 12'h444;
            else            exp_rgb = pix;
            check($sformatf("ovl_rgb_col%0d", k), vout.rgb, exp_rgb);
            check("ovl_hcount", vout.hcount, X0 + k);
            check("ovl_vcount", vout.vcount, Y0);
        end
        set_pixel(0, 0, 12'h000);
        tick(12);

        // Re-press during HOLD.
        press_and_hold(8);
        check("repress_first_force", throw_force, 2);
        tick(3);
        charge_btn = 1'b1;
        tick(1);
        check("repress_busy", busy, 1);
        check("repress_keep_force", throw_force, 2);
        set_pixel(X0, Y0, 12'h0A5);
        tick(1);
        check("repress_level0_track", vout.rgb, 12'h444);
        tick(19);
        check("repress_force_before_rel", throw_force, 2);
        charge_btn = 1'b0;
        tick(1);
        check("repress_force", throw_force, 5);
        check("repress_valid", force_valid, 1);
        tick(12);

        // Reset mid-charge at level 5.
        charge_btn = 1'b1;
        tick(1);
        tick(20);
        check("midrst_fill", vout.rgb, 12'hF00);
        check("midrst_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_force", throw_force, 0);
        check("midrst_rgb", vout.rgb, 0);
        charge_btn = 1'b0;
        fv_base = fv_count;
        tick(2);
        rst = 1'b0;
        tick(5);
        check("midrst_no_pulse", fv_count - fv_base, 0);
        check("midrst_idle", busy, 0);
        check("midrst_passthru", vout.rgb, 12'h0A5);

        // Button already held when reset is released.
        rst        = 1'b1;
        charge_btn = 1'b1;
        tick(1);
        rst = 1'b0;
        check("held_rst_busy0", busy, 0);
        tick(1);
        check("held_rst_charge", busy, 1);
        charge_btn = 1'b0;
        tick(1);
        check("held_rst_valid", force_valid, 1);
        check("held_rst_force", throw_force, 0);
        tick(12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
